// File: rtl/rr_otf_converter_if.sv
// Online digit interface: signed-digit stream in, two's-complement result out.
// master drives digits and consumes results; slave is the converter.
interface rr_otf_converter_if #(
    parameter int WIDTH = 7,
    parameter int RADIX = 2
);
    localparam int K  = $clog2(RADIX);
    localparam int D  = K + 1;
    localparam int QW = K * WIDTH + 1;

    // A digit transfers on any cycle with d_valid && d_ready.
    // d_ready is held high, so the source never stalls.
    logic [D-1:0]  d_in;
    logic          d_valid;
    logic          d_sof;
    logic          d_ready;
    logic [QW-1:0] q_out;
    logic          q_valid;
    logic          q_err;
    logic          busy;

    modport master (
        output d_in, d_valid, d_sof,
        input  d_ready, q_out, q_valid, q_err, busy
    );

    modport slave (
        input  d_in, d_valid, d_sof,
        output d_ready, q_out, q_valid, q_err, busy
    );
endinterface

// File: rtl/rr_otf_converter.sv
// MSD-first signed-digit to two's-complement converter using Q/QM on-the-fly
// conversion; one result per WIDTH accepted digits, one cycle after the last.
module rr_otf_converter #(
    parameter int WIDTH = 7,
    parameter int RADIX = 2
) (
    input logic              clock,
    input logic              reset_n,
    rr_otf_converter_if.slave bus
);
    localparam int K  = $clog2(RADIX);
    localparam int D  = K + 1;
    localparam int QW = K * WIDTH + 1;
    localparam int QL = QW - K;            // only these bits feed the next shift
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state;
    logic [QL-1:0] q, qm;
    logic [CW-1:0] cnt;
    logic          err;

    logic          first, neg, pos, illegal, done, err_nx;
    logic [QL-1:0] src_q, src_qm;
    logic [K-1:0]  lo_neg, lo_dec, lo_qm;
    logic [QW-1:0] q_nx;
    logic [QL-1:0] qm_nx;
    logic [CW-1:0] cnt_nx;

    always_comb begin
        // A new frame starts from Q=0 / QM=-1 rather than the stale registers.
        first   = (state == IDLE) || bus.d_sof;
        src_q   = first ? '0 : q;
        src_qm  = first ? '1 : qm;
        neg     = bus.d_in[D-1];
        pos     = !neg && (bus.d_in != '0);
        illegal = (bus.d_in == {1'b1, {K{1'b0}}});
        // RADIX is 0 modulo 2^K, so (RADIX+d) keeps the digit's low bits.
        lo_neg  = bus.d_in[K-1:0];
        lo_dec  = bus.d_in[K-1:0] - K'(1);
        lo_qm   = bus.d_in[K-1:0] + K'(RADIX - 1);
        q_nx    = neg ? {src_qm, lo_neg} : {src_q, bus.d_in[K-1:0]};
        qm_nx   = pos ? {src_q[QL-K-1:0], lo_dec} : {src_qm[QL-K-1:0], lo_qm};
        cnt_nx  = first ? CW'(1) : cnt + CW'(1);
        done    = (cnt_nx == CW'(WIDTH));
        err_nx  = (first ? 1'b0 : err) | illegal;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            q           <= '0;
            qm          <= '1;
            cnt         <= '0;
            err         <= 1'b0;
            bus.q_out   <= '0;
            bus.q_valid <= 1'b0;
            bus.q_err   <= 1'b0;
        end else begin
            bus.q_valid <= 1'b0;
            if (bus.d_valid) begin
                q  <= q_nx[QL-1:0];
                qm <= qm_nx;
                if (done) begin
                    state       <= IDLE;
                    cnt         <= '0;
                    err         <= 1'b0;
                    bus.q_out   <= q_nx;
                    bus.q_valid <= 1'b1;
                    bus.q_err   <= err_nx;
                end else begin
                    state <= RUN;
                    cnt   <= cnt_nx;
                    err   <= err_nx;
                end
            end
        end
    end

    assign bus.d_ready = 1'b1;
    assign bus.busy    = (state == RUN);
endmodule

// File: tb/tb_rr_otf_converter.sv
// Bench for rr_otf_converter: a RADIX=4/WIDTH=3 and a RADIX=2/WIDTH=7 instance
// checked against a digit-sum reference model.
module tb_rr_otf_converter;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    rr_otf_converter_if #(.WIDTH(3), .RADIX(4)) ia ();
    rr_otf_converter_if #(.WIDTH(7), .RADIX(2)) ib ();

    rr_otf_converter #(.WIDTH(3), .RADIX(4)) dut_a (.clock(clock), .reset_n(reset_n), .bus(ia.slave));
    rr_otf_converter #(.WIDTH(7), .RADIX(2)) dut_b (.clock(clock), .reset_n(reset_n), .bus(ib.slave));

    int n_vec = 0;
    int n_err = 0;

    // model state per unit: digits taken, running value, error flag, last result
    int               n_dig[2];
    longint           acc[2];
    bit               ferr[2];
    logic signed [63:0] held_q[2];
    logic             held_err[2];
    logic [64:0]      exp_q0[$];
    logic [64:0]      exp_q1[$];

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int u, output logic v, output logic signed [63:0] q,
                          output logic e, output logic b, output logic r);
        if (u == 0) begin
            v = ia.q_valid; q = 64'($signed(ia.q_out)); e = ia.q_err; b = ia.busy; r = ia.d_ready;
        end else begin
            v = ib.q_valid; q = 64'($signed(ib.q_out)); e = ib.q_err; b = ib.busy; r = ib.d_ready;
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            n_dig[u] = 0; acc[u] = 0; ferr[u] = 0; held_q[u] = 0; held_err[u] = 1'b0;
        end
    endtask

    task automatic check_reset_values(input int u, input string when);
        logic v, e, b, r;
        logic signed [63:0] q;
        string nm;
        nm = (u == 0) ? "a" : "b";
        sample(u, v, q, e, b, r);
        check($sformatf("%s.%s.q_out", nm, when), q, 0);
        check($sformatf("%s.%s.q_valid", nm, when), v, 0);
        check($sformatf("%s.%s.q_err", nm, when), e, 0);
        check($sformatf("%s.%s.busy", nm, when), b, 0);
        check($sformatf("%s.%s.d_ready", nm, when), r, 1);
    endtask

    // One clock: drive unit u (the other unit idles), then compare after the edge.
    task automatic step(input int u, input int d, input bit v, input bit sof);
        logic ov, oe, ob, orr;
        logic signed [63:0] oq;
        logic [64:0] ent;
        bit exp_v;
        int R, W;
        string nm;
        R  = (u == 0) ? 4 : 2;
        W  = (u == 0) ? 3 : 7;
        nm = (u == 0) ? "a" : "b";
        @(negedge clock);
        ia.d_valid = 1'b0; ia.d_sof = 1'b0;
        ib.d_valid = 1'b0; ib.d_sof = 1'b0;
        if (u == 0) begin
            ia.d_in = 3'(d); ia.d_valid = v; ia.d_sof = sof;
        end else begin
            ib.d_in = 2'(d); ib.d_valid = v; ib.d_sof = sof;
        end
        @(posedge clock);
        #1;
        exp_v = 1'b0;
        if (v) begin
            if (sof || n_dig[u] == 0) begin
                n_dig[u] = 0; acc[u] = 0; ferr[u] = 1'b0;
            end
            acc[u] = acc[u] * R + d;
            if (d == -R) ferr[u] = 1'b1;
            n_dig[u]++;
            if (n_dig[u] == W) begin
                exp_v = 1'b1;
                n_dig[u] = 0;
                if (u == 0) exp_q0.push_back({ferr[u], 64'(acc[u])});
                else        exp_q1.push_back({ferr[u], 64'(acc[u])});
            end
        end
        sample(u, ov, oq, oe, ob, orr);
        if (ov === 1'b1) begin
            if (u == 0 && exp_q0.size() > 0) begin
                ent = exp_q0.pop_front(); held_q[0] = ent[63:0]; held_err[0] = ent[64];
            end
            if (u == 1 && exp_q1.size() > 0) begin
                ent = exp_q1.pop_front(); held_q[1] = ent[63:0]; held_err[1] = ent[64];
            end
        end
        check($sformatf("%s.q_valid", nm), ov, exp_v);
        check($sformatf("%s.busy", nm), ob, n_dig[u] > 0);
        check($sformatf("%s.q_out", nm), oq, held_q[u]);
        check($sformatf("%s.q_err", nm), oe, held_err[u]);
        check($sformatf("%s.d_ready", nm), orr, 1);
    endtask

    initial begin
        int u, R, d;
        bit v, sof;
        ia.d_in = '0; ia.d_valid = 1'b0; ia.d_sof = 1'b0;
        ib.d_in = '0; ib.d_valid = 1'b0; ib.d_sof = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_reset_values(0, "reset");
        check_reset_values(1, "reset");
        @(negedge clock);
        reset_n = 1'b1;

        // 1,-2,3 with an idle cycle mid-frame -> 11
        step(0, 1, 1, 0); step(0, 0, 0, 0); step(0, -2, 1, 0); step(0, 3, 1, 0);
        step(0, 0, 0, 0);
        // -1,0,0 then 3,3,3 back-to-back -> -16, 63
        step(0, -1, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
        step(0, 3, 1, 0); step(0, 3, 1, 0); step(0, 3, 1, 0);
        step(0, 0, 0, 0);
        // illegal digit mid-frame -> 16 with error, then clean frame -> 1
        step(0, 2, 1, 0); step(0, -4, 1, 0); step(0, 0, 1, 0);
        step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 1, 1, 0);
        // illegal digit as last digit -> -4 with error
        step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, -4, 1, 0);
        // sof restart discards 3,3; then 1,0,2 -> 18
        step(0, 3, 1, 1); step(0, 3, 1, 0); step(0, 1, 1, 1); step(0, 0, 1, 0); step(0, 2, 1, 0);
        // sof on the very first digit of a frame behaves as a plain start
        step(0, -3, 1, 1); step(0, 3, 1, 0); step(0, -3, 1, 0);
        // radix 2: 1,-1 x6 -> 1, then all -1 -> -127
        step(1, 1, 1, 0);
        for (int i = 0; i < 6; i++) step(1, -1, 1, 0);
        for (int i = 0; i < 7; i++) step(1, -1, 1, 0);
        step(1, 0, 0, 0);

        // asynchronous reset in the middle of a frame
        step(0, 1, 1, 0); step(0, 1, 1, 0);
        @(negedge clock);
        ia.d_valid = 1'b0; ib.d_valid = 1'b0; ia.d_sof = 1'b0; ib.d_sof = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_values(0, "async_reset");
        check_reset_values(1, "async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, -1, 1, 0);

        // randomized legal digits, idle cycles and sof restarts on both units
        for (int i = 0; i < 400; i++) begin
            u   = int'($urandom_range(0, 1));
            R   = (u == 0) ? 4 : 2;
            v   = ($urandom_range(0, 3) != 0);
            sof = ($urandom_range(0, 9) == 0);
            d   = int'($urandom_range(0, 2 * R - 2)) - (R - 1);
            step(u, d, v, sof);
        end
        step(0, 0, 0, 0);

        check("a.pending_results", exp_q0.size(), 0);
        check("b.pending_results", exp_q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
